// File: rtl/tau_pkg.sv
// Shared definitions for the RV32I decode stage: widths, base opcodes and
// the immediate-format selector used between the decoder and decode_imm_gen.
package tau_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int NREGS = 32;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_e;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: rebuilds the sign-extended 32-bit
// immediate for the selected RV32I format. instr[6:0] is never part of an
// immediate, so only instr[31:7] is taken.
module decode_imm_gen
  import tau_pkg::*;
(
  input  logic [31:7]     i_instr,
  input  imm_fmt_e        i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic w_sign;
  assign w_sign = i_instr[31];

  // Select immediate bit layout by format
  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I: o_imm = {{20{w_sign}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'b0};
      IMM_J: o_imm = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction into a single output pipeline
// register and tracks in-flight destination registers in a busy scoreboard
// that blocks issue on RAW/WAW hazards until writeback retires them.
// Optional build macro DECODE_STALL_CNT_EN adds the stall_cnt port/counter.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready never depends on in_valid; once out_valid is high the output
// fields hold until out_ready is seen (or flush discards them).
module decode_stage
  import tau_pkg::*;
#(
  parameter int XLEN_P  = 32,
  parameter int NREGS_P = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN_P-1:0]   in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN_P-1:0]   out_pc,
  output logic [REG_W-1:0]    out_rs1,
  output logic [REG_W-1:0]    out_rs2,
  output logic [REG_W-1:0]    out_rd,
  output logic                out_rd_we,
  output logic [XLEN_P-1:0]   out_imm,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_illegal,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                flush
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  logic [NREGS_P-1:0] r_busy;
  logic [NREGS_P-1:0] w_busy_nxt;

  logic [6:0]       w_opcode;
  logic [REG_W-1:0] w_rs1_idx;
  logic [REG_W-1:0] w_rs2_idx;
  logic [REG_W-1:0] w_rd_idx;
  logic             w_use_rs1;
  logic             w_use_rs2;
  logic             w_wr_rd;
  logic             w_illegal;
  imm_fmt_e         w_fmt;
  logic [XLEN-1:0]  w_imm;
  logic [REG_W-1:0] w_rs1;
  logic [REG_W-1:0] w_rs2;
  logic             w_rd_we;
  logic             w_hazard;
  logic             w_accept;

  assign w_opcode  = in_instr[6:0];
  assign w_rs1_idx = in_instr[19:15];
  assign w_rs2_idx = in_instr[24:20];
  assign w_rd_idx  = in_instr[11:7];

  // Opcode classification: which fields are read/written and immediate format
  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_wr_rd   = 1'b0;
    w_illegal = 1'b0;
    w_fmt     = IMM_I;
    case (w_opcode)
      OPC_LUI:      begin w_wr_rd = 1'b1; w_fmt = IMM_U; end
      OPC_AUIPC:    begin w_wr_rd = 1'b1; w_fmt = IMM_U; end
      OPC_JAL:      begin w_wr_rd = 1'b1; w_fmt = IMM_J; end
      OPC_JALR:     begin w_use_rs1 = 1'b1; w_wr_rd = 1'b1; w_fmt = IMM_I; end
      OPC_BRANCH:   begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_fmt = IMM_B; end
      OPC_LOAD:     begin w_use_rs1 = 1'b1; w_wr_rd = 1'b1; w_fmt = IMM_I; end
      OPC_STORE:    begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_fmt = IMM_S; end
      OPC_OP_IMM:   begin w_use_rs1 = 1'b1; w_wr_rd = 1'b1; w_fmt = IMM_I; end
      OPC_OP:       begin w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_wr_rd = 1'b1; end
      OPC_MISC_MEM: w_fmt = IMM_I;
      OPC_SYSTEM:   w_fmt = IMM_I;
      default:      w_illegal = 1'b1;
    endcase
  end

  decode_imm_gen u_imm_gen (
    .i_instr (in_instr[31:7]),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Unused source indices read as x0; writes to x0 never mark anything busy
  assign w_rs1   = w_use_rs1 ? w_rs1_idx : '0;
  assign w_rs2   = w_use_rs2 ? w_rs2_idx : '0;
  assign w_rd_we = w_wr_rd & (w_rd_idx != '0);

  assign w_hazard = (w_use_rs1 & r_busy[w_rs1]) |
                    (w_use_rs2 & r_busy[w_rs2]) |
                    (w_rd_we   & r_busy[w_rd_idx]);

  assign in_ready = (~out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;

  // Scoreboard next state: clears from writeback and flush, then set on accept.
  // A set never collides with a clear of the same index (WAW blocks accept),
  // and accept cannot happen during flush.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid && (wb_rd != '0))
      w_busy_nxt[wb_rd] = 1'b0;
    if (flush && out_valid && out_rd_we)
      w_busy_nxt[out_rd] = 1'b0;
    if (w_accept && w_rd_we)
      w_busy_nxt[w_rd_idx] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Output valid: flush wins, accept loads, consumption empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             out_valid <= 1'b0;
    else if (flush)         out_valid <= 1'b0;
    else if (w_accept)      out_valid <= 1'b1;
    else if (out_ready)     out_valid <= 1'b0;
  end

  // Output payload: loaded only on accept, otherwise held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_imm     <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_illegal <= 1'b0;
    end else if (w_accept) begin
      out_pc      <= in_pc;
      out_rs1     <= w_rs1;
      out_rs2     <= w_rs2;
      out_rd      <= w_rd_idx;
      out_rd_we   <= w_rd_we;
      out_imm     <= w_imm;
      out_opcode  <= w_opcode;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_illegal <= w_illegal;
    end
  end

`ifdef DECODE_STALL_CNT_EN
  // Saturating count of cycles an offered instruction is held by a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (in_valid && w_hazard && !flush && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
